// File: rtl/zstr_ser_pkg.sv
// zstr_ser_pkg -- definitions shared by the zstr streaming blocks.
//
// Handshake (used on every zstr port): a word or beat moves across a port in
// exactly those cycles where vld and ack are both 1. A receiver may raise ack
// while vld is low, and neither side waits for the other's vld before
// asserting its own signal, so ack never depends on vld on the same port.
//
// Contents:
//   zstr_state_e  logical state of a serializer (IDLE / SHIFT / LAST)
//   zstr_clog2    constant function for counter widths (result >= 1)
package zstr_ser_pkg;

  typedef enum logic [1:0] {
    ZS_IDLE  = 2'd0,  // no word held
    ZS_SHIFT = 2'd1,  // word held, more beats follow the current one
    ZS_LAST  = 2'd2   // word held, current beat is the final one
  } zstr_state_e;

  // Bits needed to count 0..value-1; never returns less than 1 so a counter
  // declared with it always has at least one bit.
  function automatic int zstr_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/zstr_ser.sv
// zstr_ser -- wide-to-narrow stream serializer.
//
// Accepts one N*BW-bit word on the zi port and emits it as N beats of BW bits
// on the zo port, least-significant slice first (LSBF=1) or most-significant
// slice first (LSBF=0). A new word can be taken in the same cycle the final
// beat of the previous word leaves, so back-to-back words flow without a
// bubble.
//
// Ports:
//   z_clk    in   clock, all state on rising edge
//   z_rst    in   asynchronous active-low reset (deassertion synchronised
//                 outside this block)
//   zi_vld   in   input word valid
//   zi_bus   in   input word, N*BW bits
//   zi_ack   out  input acknowledge (combinational from zo_ack only)
//   zo_vld   out  output beat valid (straight from a flop)
//   zo_bus   out  output beat, BW bits
//   zo_last  out  final beat of the current word
//   zo_ack   in   output acknowledge
module zstr_ser
  import zstr_ser_pkg::*;
#(
  parameter int BW   = 8,
  parameter int N    = 4,
  parameter int LSBF = 1
) (
  input  logic            z_clk,
  input  logic            z_rst,
  input  logic            zi_vld,
  input  logic [N*BW-1:0] zi_bus,
  output logic            zi_ack,
  output logic            zo_vld,
  output logic [BW-1:0]   zo_bus,
  output logic            zo_last,
  input  logic            zo_ack
);

  localparam int            CW     = zstr_clog2(N);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  logic [N*BW-1:0] d_q;    // held word, not reset (contents ignored while idle)
  logic [CW-1:0]   c_q;    // index of the beat currently presented
  logic            v_q;    // a word is held
  zstr_state_e     state;  // decoded logical state, for observation and decode
  logic            in_xfer;
  logic            out_xfer;
  logic [CW-1:0]   slice_idx;

  always_comb begin
    state = ZS_IDLE;
    if (v_q) begin
      state = (c_q == C_LAST) ? ZS_LAST : ZS_SHIFT;
    end
  end

  // zi_ack is the only combinational path: the final beat leaving frees the
  // register for the next word in the same cycle.
  assign zi_ack   = (state == ZS_IDLE) | (zo_ack & (state == ZS_LAST));
  assign in_xfer  = zi_vld & zi_ack;
  assign out_xfer = v_q & zo_ack;

  assign zo_vld  = v_q;
  assign zo_last = (state == ZS_LAST);

  assign slice_idx = (LSBF != 0) ? c_q : (C_LAST - c_q);
  assign zo_bus    = d_q[int'(slice_idx)*BW +: BW];

  // Control state. An input transfer while a word is held can only happen in
  // LAST with the final beat leaving, so it takes priority over advancing.
  always_ff @(posedge z_clk or negedge z_rst) begin
    if (!z_rst) begin
      v_q <= 1'b0;
      c_q <= '0;
    end else if (in_xfer) begin
      v_q <= 1'b1;
      c_q <= '0;
    end else if (out_xfer) begin
      if (c_q == C_LAST) begin
        v_q <= 1'b0;
        c_q <= '0;
      end else begin
        c_q <= c_q + CW'(1);
      end
    end
  end

  // Data is sampled only on an input transfer.
  always_ff @(posedge z_clk) begin
    if (in_xfer) begin
      d_q <= zi_bus;
    end
  end

endmodule

// File: doc/zstr_ser.md
ZSTR_SER -- requirements
Module: zstr_ser

Interface
REQ-001 SHALL have parameter BW, default 8, output beat width in bits (BW >= 1).
REQ-002 SHALL have parameter N, default 4, beats per input word (N >= 2).
REQ-003 SHALL have parameter LSBF, default 1, slice order: 1 = least-significant slice first, 0 = most-significant first.
REQ-004 z_clk  input  1  system clock; one clock domain; all state on rising edge.
REQ-005 z_rst  input  1  asynchronous, active-low reset.
REQ-006 zi_vld  input  1  input word valid.
REQ-007 zi_bus  input  N*BW  input word.
REQ-008 zi_ack  output  1  input acknowledge.
REQ-009 zo_vld  output  1  output beat valid.
REQ-010 zo_bus  output  BW  output beat.
REQ-011 zo_last  output  1  marks the final beat of a word.
REQ-012 zo_ack  input  1  output acknowledge.

Function
REQ-013 Transfer on either port SHALL occur exactly in a cycle where vld & ack are both 1.
REQ-014 ack MAY be high while vld is low; neither side SHALL wait for the other's vld before raising ack.
REQ-015 State: data register D[N*BW-1:0], beat counter C[clog2(N)-1:0], valid flag V.
REQ-016 Logical states: IDLE (V=0), SHIFT (V=1, C<N-1), LAST (V=1, C=N-1).
REQ-017 zo_vld SHALL equal V, driven directly from a flop.
REQ-018 zo_bus SHALL be slice C of D when LSBF=1; slice N-1-C when LSBF=0; slice k = D[k*BW +: BW].
REQ-019 zo_last SHALL equal V & (C == N-1).
REQ-020 zi_ack SHALL equal ~V | (zo_ack & C == N-1); the only combinational path through the block is zo_ack -> zi_ack.
REQ-021 IDLE, input transfer: load D <= zi_bus, C <= 0, V <= 1; first beat SHALL appear on zo_vld in the next cycle (latency 1).
REQ-022 SHIFT, output transfer: C <= C+1; D unchanged.
REQ-023 LAST, output transfer with simultaneous input transfer: load D, C <= 0, V stays 1, giving zero-bubble back-to-back words (N beats per N cycles sustained).
REQ-024 LAST, output transfer without input transfer: V <= 0, C <= 0.
REQ-025 V=1 and zo_ack=0: D, C and V SHALL hold; zo_bus and zo_last SHALL be stable.
REQ-026 zi_bus SHALL be sampled only on an input transfer; its value at any other cycle SHALL be ignored.
REQ-027 C SHALL never exceed N-1; for N not a power of two, it wraps from N-1 to 0 only via REQ-023/REQ-024.

Reset
REQ-028 While z_rst=0: V=0, C=0, zo_vld=0, zo_last=0, zi_ack=1.
REQ-029 D SHALL not be reset; zo_bus is don't-care while zo_vld=0.
REQ-030 Reset asserted mid-word SHALL discard the partially sent word; no beats of it SHALL appear after release.
REQ-031 Reset deassertion SHALL be synchronised externally; the block itself adds no synchroniser.

Structure
REQ-032 The clog2 function SHALL live in the shared zstr include/package, with the handshake definition used by all zstr blocks.
REQ-033 No sub-module is needed; single flat module.
REQ-034 The block SHALL be instantiable directly upstream of zstr_reg (narrow side) without glue.

Verification (BW=8, N=4, LSBF=1 unless noted)
REQ-035 Single word: zi_bus=0xDDCCBBAA for 1 cycle, zo_ack=1 -> zo_bus 0xAA,0xBB,0xCC,0xDD on cycles t+1..t+4; zo_last only on 0xDD; zi_ack=0 during t+1..t+3.
REQ-036 Back-to-back: words 0x03020100 and 0x07060504, zi_vld held, zo_ack=1 -> 8 consecutive beats 0x00..0x07, no bubble; second word accepted in the cycle 0x03 transfers.
REQ-037 Backpressure: zo_ack=0 for 3 cycles while showing 0xBB -> zo_bus=0xBB, zo_vld=1 held for all 3 cycles; sequence resumes at 0xCC; nothing lost or duplicated.
REQ-038 LSBF=0: zi_bus=0x11223344 -> beats 0x11,0x22,0x33,0x44; zo_last on 0x44.
REQ-039 Reset mid-word: z_rst low after beat 0xBB -> zo_vld=0 and zi_ack=1 during reset; after release only newly accepted words appear.
REQ-040 Random zi_vld/zo_ack at 50% each, N=3, 1000 words -> scoreboard matches all beats in order; zo_last count = 1000.
